// File: rtl/debug_hexmon.sv
// Debug probe monitor: latches NCH probe channels, keeps a ring history of one
// channel and drives an active-low hex display with freeze/browse through history.
module debug_hexmon #(
  parameter int NCH     = 3,
  parameter int W       = 16,
  parameter int DIGITS  = 4,
  parameter int SEL_W   = 2,
  parameter int HIST_CH = 0,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic                  clk25,
  input  logic                  reset_n,
  input  logic [NCH*W-1:0]      ch_data,
  input  logic [NCH-1:0]        ch_strobe,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  freeze,
  input  logic                  hist_prev,
  input  logic                  hist_next,
  output logic [7*DIGITS-1:0]   seg,
  output logic [AW-1:0]         hist_offset,
  output logic [AW:0]           hist_count,
  output logic                  wrapped
);

  localparam int SW = 4 * DIGITS;

  logic [W-1:0]          cap_r [NCH];
  logic [W-1:0]          mem_r [DEPTH];
  logic [AW-1:0]         wptr_r;
  logic [AW-1:0]         hist_offset_r;
  logic [AW:0]           hist_count_r;
  logic                  wrapped_r;
  logic                  prev_q_r;
  logic                  next_q_r;
  logic [7*DIGITS-1:0]   seg_r;

  logic                  hist_we_s;
  logic                  prev_edge_s;
  logic                  next_edge_s;
  logic [AW-1:0]         rd_idx_s;
  logic [SW-1:0]         src_s;
  logic                  blank_s;
  logic [7*DIGITS-1:0]   seg_next_s;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      4'hF:    hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  assign hist_we_s   = ~freeze & ch_strobe[HIST_CH];
  assign prev_edge_s = hist_prev & ~prev_q_r;
  assign next_edge_s = hist_next & ~next_q_r;
  assign rd_idx_s    = wptr_r - AW'(1) - hist_offset_r;

  // Probe capture registers and history bookkeeping.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) cap_r[i] <= '0;
      wptr_r       <= '0;
      hist_count_r <= '0;
      wrapped_r    <= 1'b0;
    end else if (!freeze) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_strobe[i]) cap_r[i] <= ch_data[i*W +: W];
      end
      if (ch_strobe[HIST_CH]) begin
        wptr_r <= wptr_r + AW'(1);
        if (hist_count_r == (AW+1)'(DEPTH)) wrapped_r <= 1'b1;
        else hist_count_r <= hist_count_r + (AW+1)'(1);
      end
    end
  end

  // History storage; contents are meaningless until hist_count says otherwise.
  always_ff @(posedge clk25) begin
    if (hist_we_s) mem_r[wptr_r] <= ch_data[HIST_CH*W +: W];
  end

  // Key edge detection and browse offset.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      prev_q_r      <= 1'b0;
      next_q_r      <= 1'b0;
      hist_offset_r <= '0;
    end else begin
      prev_q_r <= hist_prev;
      next_q_r <= hist_next;
      if (!freeze) begin
        hist_offset_r <= '0;
      end else if (prev_edge_s && !next_edge_s) begin
        if (hist_count_r != '0 && {1'b0, hist_offset_r} < hist_count_r - (AW+1)'(1))
          hist_offset_r <= hist_offset_r + AW'(1);
      end else if (next_edge_s && !prev_edge_s) begin
        if (hist_offset_r != '0) hist_offset_r <= hist_offset_r - AW'(1);
      end
    end
  end

  // Display source selection and hex encoding.
  always_comb begin
    src_s   = '0;
    blank_s = 1'b1;
    if (int'(sel) < NCH) begin
      src_s[W-1:0] = cap_r[sel];
      blank_s      = 1'b0;
    end else if (int'(sel) == NCH) begin
      if (hist_count_r != '0) begin
        src_s[W-1:0] = mem_r[rd_idx_s];
        blank_s      = 1'b0;
      end else begin
        blank_s = 1'b1;
      end
    end else begin
      blank_s = 1'b1;
    end
    for (int d = 0; d < DIGITS; d++) begin
      seg_next_s[7*d +: 7] = blank_s ? 7'h7F : hex7(src_s[4*d +: 4]);
    end
  end

  // Registered segment drive.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) seg_r <= '1;
    else          seg_r <= seg_next_s;
  end

  assign seg         = seg_r;
  assign hist_offset = hist_offset_r;
  assign hist_count  = hist_count_r;
  assign wrapped     = wrapped_r;

endmodule

// File: tb/tb_debug_hexmon.sv
// Randomised bench for debug_hexmon against a queue-based behavioural model,
// with literal expectations from hand-worked display values.
module tb_debug_hexmon;
  localparam int NCH = 3, W = 16, DIGITS = 4, SEL_W = 2, HIST_CH = 0, DEPTH = 16, AW = 4;
  localparam logic [6:0] TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                clk25 = 1'b0;
  logic                reset_n = 1'b0;
  logic [NCH*W-1:0]    ch_data = '0;
  logic [NCH-1:0]      ch_strobe = '0;
  logic [SEL_W-1:0]    sel = '0;
  logic                freeze = 1'b0;
  logic                hist_prev = 1'b0;
  logic                hist_next = 1'b0;
  logic [7*DIGITS-1:0] seg;
  logic [AW-1:0]       hist_offset;
  logic [AW:0]         hist_count;
  logic                wrapped;

  debug_hexmon #(.NCH(NCH), .W(W), .DIGITS(DIGITS), .SEL_W(SEL_W), .HIST_CH(HIST_CH),
                 .DEPTH(DEPTH), .AW(AW)) dut (
    .clk25(clk25), .reset_n(reset_n), .ch_data(ch_data), .ch_strobe(ch_strobe), .sel(sel),
    .freeze(freeze), .hist_prev(hist_prev), .hist_next(hist_next), .seg(seg),
    .hist_offset(hist_offset), .hist_count(hist_count), .wrapped(wrapped));

  always #20 clk25 = ~clk25;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [W-1:0]        m_cap [NCH];
  logic [W-1:0]        m_hist [$];
  int                  m_off;
  bit                  m_wrapped;
  bit                  m_pq, m_nq;
  logic [7*DIGITS-1:0] m_seg;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7*DIGITS-1:0] render();
    logic [4*DIGITS-1:0] v;
    logic [7*DIGITS-1:0] r;
    bit blank;
    int s;
    v = '0;
    blank = 1'b0;
    s = int'(sel);
    if (s < NCH) v[W-1:0] = m_cap[s];
    else if (s == NCH && m_hist.size() > 0) v[W-1:0] = m_hist[m_hist.size()-1-m_off];
    else blank = 1'b1;
    for (int d = 0; d < DIGITS; d++) r[7*d +: 7] = blank ? 7'h7F : TAB[v[4*d +: 4]];
    return r;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) m_cap[c] = '0;
    m_hist.delete();
    m_off = 0;
    m_wrapped = 1'b0;
    m_pq = 1'b0;
    m_nq = 1'b0;
    m_seg = '1;
  endfunction

  function automatic void model_step();
    bit pe, ne;
    m_seg = render();
    pe = hist_prev && !m_pq;
    ne = hist_next && !m_nq;
    m_pq = hist_prev;
    m_nq = hist_next;
    if (!freeze) begin
      for (int c = 0; c < NCH; c++) if (ch_strobe[c]) m_cap[c] = ch_data[c*W +: W];
      if (ch_strobe[HIST_CH]) begin
        if (m_hist.size() == DEPTH) begin
          m_wrapped = 1'b1;
          void'(m_hist.pop_front());
        end
        m_hist.push_back(ch_data[HIST_CH*W +: W]);
      end
      m_off = 0;
    end else if (pe && !ne) begin
      if (m_off < m_hist.size() - 1) m_off++;
    end else if (ne && !pe && m_off > 0) begin
      m_off--;
    end
  endfunction

  // One clock: model follows the edge, outputs are compared on the falling edge,
  // and new stimulus is applied just after it.
  task automatic tick();
    @(posedge clk25);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk25);
    #1;
  endtask

  task automatic strobe1(input int ch, input logic [W-1:0] v);
    ch_data[ch*W +: W] = v;
    ch_strobe = NCH'(1) << ch;
    tick();
    ch_strobe = '0;
  endtask

  task automatic key_prev();
    hist_prev = 1'b1; tick();
    hist_prev = 1'b0; tick();
  endtask

  task automatic key_next();
    hist_next = 1'b1; tick();
    hist_next = 1'b0; tick();
  endtask

  always @(negedge clk25) begin
    if (chk_en) begin
      chk("seg", 64'(seg), 64'(m_seg));
      chk("hist_count", 64'(hist_count), 64'(m_hist.size()));
      chk("hist_offset", 64'(hist_offset), 64'(m_off));
      chk("wrapped", 64'(wrapped), 64'(m_wrapped));
    end
  end

  initial begin
    model_reset();
    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NCH; c++) ch_data[c*W +: W] = W'($urandom);
      ch_strobe = NCH'($urandom);
      sel = SEL_W'($urandom);
      hist_prev = 1'(($urandom));
      hist_next = 1'(($urandom));
      tick();
      chk_en = 1'b1;
    end
    chk("rst_seg", 64'(seg), 64'(28'hFFFFFFF));
    chk("rst_count", 64'(hist_count), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    ch_strobe = '0; sel = '0; hist_prev = 1'b0; hist_next = 1'b0; freeze = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_sel0", 64'(seg), 64'({7'h40, 7'h40, 7'h40, 7'h40}));

    // Capture and select.
    ch_data[0*W +: W] = 16'h1234;
    ch_data[1*W +: W] = 16'hABCD;
    ch_strobe = 3'b011;
    tick();
    ch_strobe = '0;
    sel = 2'd0; tick();
    chk("lit_ch0", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
    sel = 2'd1; tick();
    chk("lit_ch1", 64'(seg), 64'({7'h08, 7'h03, 7'h46, 7'h21}));
    sel = 2'd3; tick();
    chk("lit_hist1234", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

    // History wrap.
    for (int v = 1; v <= 17; v++) strobe1(0, W'(v));
    tick();
    chk("lit_wrap_count", 64'(hist_count), 64'd16);
    chk("lit_wrap_flag", 64'(wrapped), 64'd1);
    chk("lit_newest", 64'(seg), 64'({7'h40, 7'h40, 7'h79, 7'h79}));

    // Browse.
    freeze = 1'b1; tick();
    for (int k = 0; k < 3; k++) key_prev();
    chk("lit_off3", 64'(hist_offset), 64'd3);
    chk("lit_off3_seg", 64'(seg), 64'({7'h40, 7'h40, 7'h40, 7'h06}));
    hist_prev = 1'b1; hist_next = 1'b1; tick();
    hist_prev = 1'b0; hist_next = 1'b0; tick();
    chk("lit_both_keys", 64'(hist_offset), 64'd3);
    for (int k = 0; k < 5; k++) key_next();
    chk("lit_next_sat", 64'(hist_offset), 64'd0);

    // Freeze blocks capture; held key steps once.
    strobe1(0, 16'h5555);
    sel = 2'd0; tick();
    chk("lit_frozen_cap", 64'(seg), 64'({7'h40, 7'h40, 7'h79, 7'h79}));
    chk("lit_frozen_count", 64'(hist_count), 64'd16);
    hist_prev = 1'b1;
    repeat (5) tick();
    hist_prev = 1'b0; tick();
    chk("lit_held_key", 64'(hist_offset), 64'd1);
    sel = 2'd3;
    for (int k = 0; k < 20; k++) key_prev();
    chk("lit_off_sat", 64'(hist_offset), 64'd15);
    chk("lit_oldest", 64'(seg), 64'({7'h40, 7'h40, 7'h40, 7'h24}));
    freeze = 1'b0; tick();
    chk("lit_unfreeze", 64'(hist_offset), 64'd0);
    strobe1(0, 16'h00AB);
    sel = 2'd0; tick();
    chk("lit_resume", 64'(seg), 64'({7'h40, 7'h40, 7'h08, 7'h03}));

    // Randomised phase with a mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) ch_data[c*W +: W] = W'($urandom);
      ch_strobe = NCH'($urandom);
      sel = SEL_W'($urandom);
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      if ($urandom_range(0, 3) == 0) hist_prev = ~hist_prev;
      if ($urandom_range(0, 3) == 0) hist_next = ~hist_next;
      reset_n = !(i >= 700 && i < 702);
      tick();
    end

    // Empty history after reset while browsing.
    freeze = 1'b1; ch_strobe = '0; hist_prev = 1'b0; hist_next = 1'b0;
    reset_n = 1'b0; tick(); tick();
    reset_n = 1'b1;
    sel = 2'd3; tick();
    chk("lit_empty_blank", 64'(seg), 64'(28'hFFFFFFF));
    key_prev();
    chk("lit_empty_prev", 64'(hist_offset), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
